// File: rtl/minisys_pkg.sv
// Shared encodings for the MEM-stage access path: access size codes, FSM states
// and the alignment rule used by both the lane aligner and the access FSM.
package minisys_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Size code 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            default: bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store enables/replication, load lane extract
// with sign/zero extension, and misalignment detection.
module mem_lane_align
    import minisys_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_sdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata,
    output logic        o_misalign
);

    logic [7:0] w_lane [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi] = i_rdata[8*gi +: 8];
        end
    endgenerate

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte     = w_lane[i_off];
    assign w_half     = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    assign o_misalign = is_misaligned(i_size, i_off);

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_sdata;
        o_ldata = i_rdata;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_sdata[7:0]}};
                o_ldata = i_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_be    = i_off[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_sdata[15:0]}};
                o_ldata = i_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: req/ack bus transaction with pipeline stall,
// bounded wait (bus error on timeout) and aligned, extended load data for MEM/WB.
module mem_access_unit
    import minisys_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        EX_MEM_MemRead,
    input  logic        EX_MEM_MemWrite,
    input  logic [1:0]  EX_MEM_Size,
    input  logic        EX_MEM_Unsigned,
    input  logic [31:0] MEM_ALU_Result,
    input  logic [31:0] EX_MEM_StoreData,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    output logic [31:0] MEM_MemData,
    output logic        MEM_Stall,
    output logic        MEM_AddrErr,
    output logic        MEM_BusErr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr;
    logic [1:0]       r_size;
    logic             r_uns;
    logic             r_we;
    logic [31:0]      r_sdata;
    logic [31:0]      r_load;
    logic             r_buserr;

    logic        w_wait;
    logic [31:0] w_addr;
    logic [1:0]  w_size;
    logic        w_uns;
    logic        w_we;
    logic [31:0] w_sdata;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ldata;
    logic [31:0] w_capture;
    logic        w_misalign;
    logic        w_memop;
    logic        w_access;
    logic        w_req;

    // While waiting, the bus is driven from the copies latched at launch.
    assign w_wait  = (r_state == ST_WAIT);
    assign w_addr  = w_wait ? r_addr  : MEM_ALU_Result;
    assign w_size  = w_wait ? r_size  : EX_MEM_Size;
    assign w_uns   = w_wait ? r_uns   : EX_MEM_Unsigned;
    assign w_we    = w_wait ? r_we    : EX_MEM_MemWrite;
    assign w_sdata = w_wait ? r_sdata : EX_MEM_StoreData;

    mem_lane_align u_align (
        .i_size     (w_size),
        .i_unsigned (w_uns),
        .i_off      (w_addr[1:0]),
        .i_sdata    (w_sdata),
        .i_rdata    (dmem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_ldata    (w_ldata),
        .o_misalign (w_misalign)
    );

    assign w_memop   = EX_MEM_MemRead | EX_MEM_MemWrite;
    assign w_access  = w_memop & ~w_misalign;
    assign w_capture = w_we ? 32'b0 : w_ldata;
    // Gating with reset makes the request drop the instant reset asserts.
    assign w_req     = reset & (((r_state == ST_IDLE) & w_access) | w_wait);

    assign dmem_req    = w_req;
    assign dmem_we     = w_req & w_we;
    assign dmem_addr   = w_req ? {w_addr[31:2], 2'b00} : 32'b0;
    assign dmem_be     = w_req ? w_be : 4'b0000;
    assign dmem_wdata  = w_req ? w_wdata : 32'b0;
    assign MEM_Stall   = w_req;
    assign MEM_AddrErr = reset & w_memop & w_misalign;
    assign MEM_MemData = (r_state == ST_DONE) ? r_load : 32'b0;
    assign MEM_BusErr  = (r_state == ST_DONE) & r_buserr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_size   <= SZ_BYTE;
            r_uns    <= 1'b0;
            r_we     <= 1'b0;
            r_sdata  <= '0;
            r_load   <= '0;
            r_buserr <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        r_addr   <= MEM_ALU_Result;
                        r_size   <= EX_MEM_Size;
                        r_uns    <= EX_MEM_Unsigned;
                        r_we     <= EX_MEM_MemWrite;
                        r_sdata  <= EX_MEM_StoreData;
                        r_cnt    <= '0;
                        r_buserr <= 1'b0;
                        if (dmem_ack) begin
                            r_load  <= w_capture;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack) begin
                        r_load  <= w_capture;
                        r_state <= ST_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_load   <= '0;
                        r_buserr <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_buserr <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: inputs change 1 time unit after the rising edge,
// outputs are sampled on the falling edge and checked against hand-computed values.
module tb_mem_access_unit;

    logic        clock;
    logic        reset;
    logic        EX_MEM_MemRead;
    logic        EX_MEM_MemWrite;
    logic [1:0]  EX_MEM_Size;
    logic        EX_MEM_Unsigned;
    logic [31:0] MEM_ALU_Result;
    logic [31:0] EX_MEM_StoreData;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] MEM_MemData;
    logic        MEM_Stall;
    logic        MEM_AddrErr;
    logic        MEM_BusErr;

    int checks   = 0;
    int failures = 0;
    int n_stall;
    bit seen_done;

    mem_access_unit #(.TIMEOUT(15)) dut (
        .clock            (clock),
        .reset            (reset),
        .EX_MEM_MemRead   (EX_MEM_MemRead),
        .EX_MEM_MemWrite  (EX_MEM_MemWrite),
        .EX_MEM_Size      (EX_MEM_Size),
        .EX_MEM_Unsigned  (EX_MEM_Unsigned),
        .MEM_ALU_Result   (MEM_ALU_Result),
        .EX_MEM_StoreData (EX_MEM_StoreData),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_be          (dmem_be),
        .dmem_wdata       (dmem_wdata),
        .MEM_MemData      (MEM_MemData),
        .MEM_Stall        (MEM_Stall),
        .MEM_AddrErr      (MEM_AddrErr),
        .MEM_BusErr       (MEM_BusErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic no_op();
        EX_MEM_MemRead   = 1'b0;
        EX_MEM_MemWrite  = 1'b0;
        EX_MEM_Size      = 2'b00;
        EX_MEM_Unsigned  = 1'b0;
        MEM_ALU_Result   = 32'h0;
        EX_MEM_StoreData = 32'h0;
        dmem_ack         = 1'b0;
        dmem_rdata       = 32'h0;
    endtask

    task automatic load(input logic [1:0] sz, input logic uns, input logic [31:0] addr);
        EX_MEM_MemRead  = 1'b1;
        EX_MEM_MemWrite = 1'b0;
        EX_MEM_Size     = sz;
        EX_MEM_Unsigned = uns;
        MEM_ALU_Result  = addr;
    endtask

    initial begin
        reset = 1'b0;
        no_op();

        // Reset state
        smp();
        chk("rst_req", {31'b0, dmem_req}, 32'h0);
        chk("rst_stall", {31'b0, MEM_Stall}, 32'h0);
        chk("rst_memdata", MEM_MemData, 32'h0);
        cyc();
        reset = 1'b1;
        smp();
        chk("idle_req", {31'b0, dmem_req}, 32'h0);
        chk("idle_buserr", {31'b0, MEM_BusErr}, 32'h0);

        // lw 0x100, ack in the first WAIT cycle
        cyc();
        load(2'b10, 1'b0, 32'h0000_0100);
        smp();
        chk("lw_idle_req", {31'b0, dmem_req}, 32'h1);
        chk("lw_idle_stall", {31'b0, MEM_Stall}, 32'h1);
        chk("lw_addr", dmem_addr, 32'h0000_0100);
        chk("lw_be", {28'b0, dmem_be}, 32'h0000_000F);
        chk("lw_we", {31'b0, dmem_we}, 32'h0);
        cyc();
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        smp();
        chk("lw_wait_req", {31'b0, dmem_req}, 32'h1);
        chk("lw_wait_stall", {31'b0, MEM_Stall}, 32'h1);
        chk("lw_wait_memdata", MEM_MemData, 32'h0);
        cyc();
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        smp();
        chk("lw_done_req", {31'b0, dmem_req}, 32'h0);
        chk("lw_done_stall", {31'b0, MEM_Stall}, 32'h0);
        chk("lw_done_memdata", MEM_MemData, 32'hDEAD_BEEF);
        cyc();
        no_op();
        smp();
        chk("lw_after_memdata", MEM_MemData, 32'h0);

        // lb 0x103 with ack in the launch cycle, then lbu
        cyc();
        load(2'b00, 1'b0, 32'h0000_0103);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h8012_3456;
        smp();
        chk("lb_be", {28'b0, dmem_be}, 32'h0000_0008);
        chk("lb_req", {31'b0, dmem_req}, 32'h1);
        cyc();
        dmem_ack = 1'b0;
        smp();
        chk("lb_done_stall", {31'b0, MEM_Stall}, 32'h0);
        chk("lb_memdata", MEM_MemData, 32'hFFFF_FF80);
        cyc();
        EX_MEM_Unsigned = 1'b1;
        dmem_ack = 1'b1;
        smp();
        chk("lbu_req", {31'b0, dmem_req}, 32'h1);
        cyc();
        dmem_ack = 1'b0;
        smp();
        chk("lbu_memdata", MEM_MemData, 32'h0000_0080);

        // lh 0x100 (sign extended), ack in launch cycle
        cyc();
        load(2'b01, 1'b0, 32'h0000_0100);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1234_F00D;
        smp();
        chk("lh_be", {28'b0, dmem_be}, 32'h0000_0003);
        cyc();
        dmem_ack = 1'b0;
        smp();
        chk("lh_memdata", MEM_MemData, 32'hFFFF_F00D);
        cyc();
        no_op();

        // sh 0x102, data 0x0000ABCD, ack in first WAIT
        EX_MEM_MemWrite  = 1'b1;
        EX_MEM_Size      = 2'b01;
        MEM_ALU_Result   = 32'h0000_0102;
        EX_MEM_StoreData = 32'h0000_ABCD;
        smp();
        chk("sh_we", {31'b0, dmem_we}, 32'h1);
        chk("sh_be", {28'b0, dmem_be}, 32'h0000_000C);
        chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        chk("sh_addr", dmem_addr, 32'h0000_0100);
        cyc();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h5555_5555;
        smp();
        chk("sh_wait_wdata", dmem_wdata, 32'hABCD_ABCD);
        chk("sh_wait_we", {31'b0, dmem_we}, 32'h1);
        cyc();
        dmem_ack = 1'b0;
        smp();
        chk("sh_done_stall", {31'b0, MEM_Stall}, 32'h0);
        chk("sh_done_memdata", MEM_MemData, 32'h0);
        cyc();
        no_op();

        // lw 0x101 is misaligned: no request, no stall
        load(2'b10, 1'b0, 32'h0000_0101);
        smp();
        chk("mis_addrerr", {31'b0, MEM_AddrErr}, 32'h1);
        chk("mis_req", {31'b0, dmem_req}, 32'h0);
        chk("mis_stall", {31'b0, MEM_Stall}, 32'h0);
        cyc();
        no_op();
        smp();
        chk("mis_after_addrerr", {31'b0, MEM_AddrErr}, 32'h0);

        // Timeout: no ack ever, expect 16 stall cycles then a BusErr pulse
        cyc();
        load(2'b10, 1'b0, 32'h0000_0200);
        n_stall = 0;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            smp();
            if (!MEM_Stall) begin
                seen_done = 1'b1;
                break;
            end
            n_stall++;
            cyc();
        end
        chk("to_reached_done", {31'b0, seen_done}, 32'h1);
        chk("to_stall_cycles", n_stall, 32'd16);
        chk("to_buserr", {31'b0, MEM_BusErr}, 32'h1);
        chk("to_memdata", MEM_MemData, 32'h0);
        chk("to_req", {31'b0, dmem_req}, 32'h0);
        cyc();
        no_op();
        smp();
        chk("to_buserr_pulse", {31'b0, MEM_BusErr}, 32'h0);

        // Reset asserted during the third WAIT cycle
        cyc();
        load(2'b10, 1'b0, 32'h0000_0300);
        cyc();
        cyc();
        cyc();
        #1;
        chk("rw_req_before", {31'b0, dmem_req}, 32'h1);
        reset = 1'b0;
        #1;
        chk("rw_req_async", {31'b0, dmem_req}, 32'h0);
        chk("rw_stall_async", {31'b0, MEM_Stall}, 32'h0);
        cyc();
        no_op();
        smp();
        reset = 1'b1;
        smp();
        chk("rw_post_req", {31'b0, dmem_req}, 32'h0);
        chk("rw_post_buserr", {31'b0, MEM_BusErr}, 32'h0);
        cyc();
        smp();
        chk("rw_post2_buserr", {31'b0, MEM_BusErr}, 32'h0);
        chk("rw_post2_stall", {31'b0, MEM_Stall}, 32'h0);

        // Next access after the aborted one works normally (ack in launch cycle)
        cyc();
        load(2'b10, 1'b0, 32'h0000_0304);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0BAD_F00D;
        cyc();
        dmem_ack = 1'b0;
        smp();
        chk("rw_next_memdata", MEM_MemData, 32'h0BAD_F00D);
        cyc();
        no_op();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
